// File: rtl/mcs4_clkrst_gen.sv
// ---------------------------------------------------------------------------
// mcs4_clkrst_gen
// Conditions the MCS-4 pad clock/reset nets for the core. It generates the
// two-phase non-overlapping clock enables, stretches the power-on clear and
// debounces the external clear, then aligns it to phase-period boundaries.
//
// Parameters
//   DIV        sysclk cycles per quarter phase period (period = 4*DIV), >= 1
//   POC_CYCLES full phase periods poc_out is held after reset release, >= 1
//   DEBOUNCE   consecutive synchronized samples to accept a clear change, >= 2
//
// Ports
//   sysclk     in   system clock, all flops rising-edge
//   poc_pad    in   power-on clear from the pad, async active-low reset
//   clear_pad  in   raw external clear request, active-high, asynchronous
//   clk1       out  phase-1 enable (registered)
//   clk2       out  phase-2 enable (registered)
//   cyc_end    out  one-cycle pulse on the last count of each phase period
//   poc_out    out  stretched power-on clear, active-high (registered)
//   clear_out  out  debounced, period-aligned clear, active-high (registered)
//   core_reset out  poc_out | clear_out
// ---------------------------------------------------------------------------
module mcs4_clkrst_gen #(
    parameter int unsigned DIV        = 2,
    parameter int unsigned POC_CYCLES = 16,
    parameter int unsigned DEBOUNCE   = 4
) (
    input  logic sysclk,
    input  logic poc_pad,
    input  logic clear_pad,
    output logic clk1,
    output logic clk2,
    output logic cyc_end,
    output logic poc_out,
    output logic clear_out,
    output logic core_reset
);

    localparam int unsigned PER   = 4 * DIV;
    localparam int unsigned PH_W  = $clog2(PER);
    localparam int unsigned POC_W = (POC_CYCLES > 1) ? $clog2(POC_CYCLES) : 1;
    localparam int unsigned DEB_W = $clog2(DEBOUNCE);

    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(PER - 1);
    localparam logic [PH_W-1:0]  PH_DIV   = PH_W'(DIV);
    localparam logic [PH_W-1:0]  PH_2DIV  = PH_W'(2 * DIV);
    localparam logic [PH_W-1:0]  PH_3DIV  = PH_W'(3 * DIV);
    localparam logic [POC_W-1:0] POC_LAST = POC_W'(POC_CYCLES - 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE - 1);

    typedef enum logic {
        CLR_IDLE   = 1'b0,
        CLR_ACTIVE = 1'b1
    } clr_state_e;

    // Synchronizers
    logic r_rst_s1;
    logic r_rst_ok;
    logic r_clr_s1;
    logic r_clr_s2;

    // State registers
    logic [PH_W-1:0]  r_ph_cnt;
    logic [POC_W-1:0] r_poc_cnt;
    logic [DEB_W-1:0] r_deb_cnt;
    clr_state_e       r_clr_state;
    logic             r_clk1;
    logic             r_clk2;
    logic             r_poc_out;
    logic             r_clear_out;

    // Next-state values
    logic [PH_W-1:0]  w_ph_cnt_nxt;
    logic [POC_W-1:0] w_poc_cnt_nxt;
    logic [DEB_W-1:0] w_deb_cnt_nxt;
    clr_state_e       w_clr_state_nxt;
    logic             w_clk1_nxt;
    logic             w_clk2_nxt;
    logic             w_poc_out_nxt;
    logic             w_clear_out_nxt;
    logic             w_cyc_end;
    logic             w_ph_last;
    logic             w_clr_req;
    logic             w_clr_mismatch;

    // Reset release synchronizer: D tied high, cleared by the pad
    always_ff @(posedge sysclk or negedge poc_pad) begin
        if (!poc_pad) begin
            r_rst_s1 <= 1'b0;
            r_rst_ok <= 1'b0;
        end else begin
            r_rst_s1 <= 1'b1;
            r_rst_ok <= r_rst_s1;
        end
    end

    // Clear request synchronizer
    always_ff @(posedge sysclk or negedge poc_pad) begin
        if (!poc_pad) begin
            r_clr_s1 <= 1'b0;
            r_clr_s2 <= 1'b0;
        end else begin
            r_clr_s1 <= clear_pad;
            r_clr_s2 <= r_clr_s1;
        end
    end

    assign w_ph_last      = (r_ph_cnt == PH_LAST);
    assign w_cyc_end      = r_rst_ok && w_ph_last;
    assign w_clr_req      = (r_clr_state == CLR_ACTIVE);
    assign w_clr_mismatch = (r_clr_s2 != w_clr_req);

    // Phase counter and phase decode; decode uses the pre-edge count
    always_comb begin
        w_ph_cnt_nxt = '0;
        w_clk1_nxt   = 1'b0;
        w_clk2_nxt   = 1'b0;
        if (r_rst_ok) begin
            w_ph_cnt_nxt = w_ph_last ? '0 : r_ph_cnt + PH_W'(1);
            w_clk1_nxt   = (r_ph_cnt < PH_DIV);
            w_clk2_nxt   = (r_ph_cnt >= PH_2DIV) && (r_ph_cnt < PH_3DIV);
        end
    end

    // Power-on clear stretch: counts period boundaries while asserted
    always_comb begin
        w_poc_cnt_nxt = r_poc_cnt;
        w_poc_out_nxt = r_poc_out;
        if (w_cyc_end && r_poc_out) begin
            if (r_poc_cnt == POC_LAST) begin
                w_poc_out_nxt = 1'b0;
            end else begin
                w_poc_cnt_nxt = r_poc_cnt + POC_W'(1);
            end
        end
    end

    // Clear debounce: a level is accepted after DEBOUNCE mismatching samples
    always_comb begin
        w_clr_state_nxt = r_clr_state;
        w_deb_cnt_nxt   = '0;
        if (w_clr_mismatch) begin
            if (r_deb_cnt == DEB_LAST) begin
                w_clr_state_nxt = r_clr_s2 ? CLR_ACTIVE : CLR_IDLE;
            end else begin
                w_deb_cnt_nxt = r_deb_cnt + DEB_W'(1);
            end
        end
    end

    // Clear alignment: only moves on a period boundary, masked by the
    // pre-edge stretched power-on clear
    always_comb begin
        w_clear_out_nxt = r_clear_out;
        if (w_cyc_end) begin
            w_clear_out_nxt = w_clr_req && !r_poc_out;
        end
    end

    // State register
    always_ff @(posedge sysclk or negedge poc_pad) begin
        if (!poc_pad) begin
            r_ph_cnt    <= '0;
            r_poc_cnt   <= '0;
            r_deb_cnt   <= '0;
            r_clr_state <= CLR_IDLE;
            r_clk1      <= 1'b0;
            r_clk2      <= 1'b0;
            r_poc_out   <= 1'b1;
            r_clear_out <= 1'b0;
        end else begin
            r_ph_cnt    <= w_ph_cnt_nxt;
            r_poc_cnt   <= w_poc_cnt_nxt;
            r_deb_cnt   <= w_deb_cnt_nxt;
            r_clr_state <= w_clr_state_nxt;
            r_clk1      <= w_clk1_nxt;
            r_clk2      <= w_clk2_nxt;
            r_poc_out   <= w_poc_out_nxt;
            r_clear_out <= w_clear_out_nxt;
        end
    end

    assign clk1       = r_clk1;
    assign clk2       = r_clk2;
    assign cyc_end    = w_cyc_end;
    assign poc_out    = r_poc_out;
    assign clear_out  = r_clear_out;
    assign core_reset = r_poc_out | r_clear_out;

endmodule

// File: tb/tb_mcs4_clkrst_gen.sv
// ---------------------------------------------------------------------------
// tb_mcs4_clkrst_gen
// Two instances: A with default parameters, B with DIV=1, POC_CYCLES=1,
// DEBOUNCE=2. Stimulus pushes hand-computed expectations, each tagged with
// the rising-edge number since poc_pad release (E1, E2, ...); per-instance
// monitors pop and compare on the falling edge after that rising edge.
// Output vector order: {clk1, clk2, cyc_end, poc_out, clear_out, core_reset}
// ---------------------------------------------------------------------------
module tb_mcs4_clkrst_gen;

    localparam logic [5:0] M_ALL = 6'b111111;
    localparam logic [5:0] M_CYC = 6'b001111;
    localparam logic [5:0] M_RST = 6'b000111;
    localparam logic [5:0] M_CLR = 6'b000011;
    localparam logic [5:0] V_RST = 6'b000101;

    typedef struct {
        int         edge_no;
        logic [5:0] mask;
        logic [5:0] val;
        string      tag;
    } exp_t;

    logic sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    logic poc_pad_a, clear_pad_a;
    logic clk1_a, clk2_a, cyc_end_a, poc_out_a, clear_out_a, core_reset_a;
    logic poc_pad_b, clear_pad_b;
    logic clk1_b, clk2_b, cyc_end_b, poc_out_b, clear_out_b, core_reset_b;
    logic [5:0] vec_a, vec_b;

    int   checks;
    int   failures;
    int   ecnt_a;
    int   ecnt_b;
    bit   done_a;
    bit   done_b;
    exp_t qa[$];
    exp_t qb[$];
    exp_t e_a, e_b, e_f;

    initial begin
        checks   = 0;
        failures = 0;
        ecnt_a   = 0;
        ecnt_b   = 0;
        done_a   = 1'b0;
        done_b   = 1'b0;
    end

    mcs4_clkrst_gen #(.DIV(2), .POC_CYCLES(16), .DEBOUNCE(4)) u_dut_a (
        .sysclk     (sysclk),
        .poc_pad    (poc_pad_a),
        .clear_pad  (clear_pad_a),
        .clk1       (clk1_a),
        .clk2       (clk2_a),
        .cyc_end    (cyc_end_a),
        .poc_out    (poc_out_a),
        .clear_out  (clear_out_a),
        .core_reset (core_reset_a)
    );

    mcs4_clkrst_gen #(.DIV(1), .POC_CYCLES(1), .DEBOUNCE(2)) u_dut_b (
        .sysclk     (sysclk),
        .poc_pad    (poc_pad_b),
        .clear_pad  (clear_pad_b),
        .clk1       (clk1_b),
        .clk2       (clk2_b),
        .cyc_end    (cyc_end_b),
        .poc_out    (poc_out_b),
        .clear_out  (clear_out_b),
        .core_reset (core_reset_b)
    );

    assign vec_a = {clk1_a, clk2_a, cyc_end_a, poc_out_a, clear_out_a, core_reset_a};
    assign vec_b = {clk1_b, clk2_b, cyc_end_b, poc_out_b, clear_out_b, core_reset_b};

    // Edge numbering relative to the latest poc_pad release
    always @(posedge sysclk) begin
        ecnt_a <= poc_pad_a ? ecnt_a + 1 : 0;
        ecnt_b <= poc_pad_b ? ecnt_b + 1 : 0;
    end

    function automatic void check_vec(input string dut, input exp_t e, input logic [5:0] act);
        checks++;
        if ((act & e.mask) !== (e.val & e.mask)) begin
            failures++;
            $display("FAIL %s %s @E%0d: got %b want %b (mask %b)",
                     dut, e.tag, e.edge_no, act, e.val, e.mask);
        end
    endfunction

    function automatic void push_a(input int n, input logic [5:0] m, input logic [5:0] v, input string t);
        exp_t x;
        x.edge_no = n; x.mask = m; x.val = v; x.tag = t;
        qa.push_back(x);
    endfunction

    function automatic void push_b(input int n, input logic [5:0] m, input logic [5:0] v, input string t);
        exp_t x;
        x.edge_no = n; x.mask = m; x.val = v; x.tag = t;
        qb.push_back(x);
    endfunction

    // Power-up sequence for the default instance (shared by both runs)
    function automatic void push_powerup_a();
        push_a(0,  M_ALL, V_RST,     "reset_state");
        push_a(1,  M_ALL, V_RST,     "hold_e1");
        push_a(2,  M_ALL, V_RST,     "hold_e2");
        push_a(3,  M_ALL, 6'b100101, "clk1_e3");
        push_a(4,  M_ALL, 6'b100101, "clk1_e4");
        push_a(5,  M_ALL, 6'b000101, "gap_e5");
        push_a(6,  M_ALL, 6'b000101, "gap_e6");
        push_a(7,  M_ALL, 6'b010101, "clk2_e7");
        push_a(8,  M_ALL, 6'b010101, "clk2_e8");
        push_a(9,  M_ALL, 6'b001101, "cyc_end_e9");
        push_a(10, M_ALL, 6'b000101, "wrap_e10");
        push_a(11, M_ALL, 6'b100101, "clk1_e11");
        push_a(17, M_ALL, 6'b001101, "cyc_end_e17");
        push_a(129, M_CYC, 6'b001101, "poc_hold");
    endfunction

    task automatic wait_a(input int n);
        int budget;
        budget = 2000;
        while (ecnt_a < n && budget > 0) begin
            @(posedge sysclk); #1;
            budget--;
        end
        if (ecnt_a < n) begin
            checks++; failures++;
            $display("FAIL A wait_E%0d: stuck at E%0d", n, ecnt_a);
        end
        #1;
    endtask

    task automatic wait_b(input int n);
        int budget;
        budget = 2000;
        while (ecnt_b < n && budget > 0) begin
            @(posedge sysclk); #1;
            budget--;
        end
        if (ecnt_b < n) begin
            checks++; failures++;
            $display("FAIL B wait_E%0d: stuck at E%0d", n, ecnt_b);
        end
        #1;
    endtask

    // Monitors: pop every expectation whose edge has been reached
    always @(negedge sysclk) begin
        while (qa.size() > 0 && qa[0].edge_no <= ecnt_a) begin
            e_a = qa.pop_front();
            if (e_a.edge_no < ecnt_a) begin
                checks++; failures++;
                $display("FAIL A %s skipped: due E%0d, now E%0d", e_a.tag, e_a.edge_no, ecnt_a);
            end else begin
                check_vec("A", e_a, vec_a);
            end
        end
        checks++;
        if (clk1_a && clk2_a) begin
            failures++;
            $display("FAIL A overlap @E%0d: clk1=%b clk2=%b want not both 1", ecnt_a, clk1_a, clk2_a);
        end
    end

    always @(negedge sysclk) begin
        while (qb.size() > 0 && qb[0].edge_no <= ecnt_b) begin
            e_b = qb.pop_front();
            if (e_b.edge_no < ecnt_b) begin
                checks++; failures++;
                $display("FAIL B %s skipped: due E%0d, now E%0d", e_b.tag, e_b.edge_no, ecnt_b);
            end else begin
                check_vec("B", e_b, vec_b);
            end
        end
        checks++;
        if (clk1_b && clk2_b) begin
            failures++;
            $display("FAIL B overlap @E%0d: clk1=%b clk2=%b want not both 1", ecnt_b, clk1_b, clk2_b);
        end
    end

    // Instance A stimulus: power-up, POC stretch, debounce, mid-run reset
    initial begin
        poc_pad_a   = 1'b1;
        clear_pad_a = 1'b0;
        #1 poc_pad_a = 1'b0;
        push_powerup_a();
        push_a(130, M_CYC, 6'b000000, "poc_fall");
        push_a(154, M_CLR, 6'b000000, "reject_3cyc_a");
        push_a(162, M_CLR, 6'b000000, "reject_3cyc_b");
        push_a(177, M_CLR, 6'b000000, "accept_before_wrap");
        push_a(178, M_CLR, 6'b000011, "accept_at_wrap");
        push_a(185, 6'b001011, 6'b001011, "clear_hold_full_period");
        push_a(186, M_CLR, 6'b000000, "clear_release_wrap");
        push_a(215, M_ALL, 6'b010011, "pre_reset_clk2_clear");
        push_a(216, M_ALL, V_RST,     "async_reset_midrun");
        repeat (5) @(posedge sysclk);
        #2 poc_pad_a = 1'b1;

        wait_a(140); clear_pad_a = 1'b1;
        wait_a(143); clear_pad_a = 1'b0;
        wait_a(170); clear_pad_a = 1'b1;
        wait_a(176); clear_pad_a = 1'b0;
        wait_a(200); clear_pad_a = 1'b1;
        wait_a(216);
        poc_pad_a   = 1'b0;
        clear_pad_a = 1'b0;
        @(posedge sysclk); #2;
        push_powerup_a();
        push_a(130, M_CYC, 6'b000000, "poc_fall_rerun");
        push_a(137, M_CYC, 6'b001000, "clear_masked_by_poc");
        push_a(138, M_RST, 6'b000011, "clear_after_poc");
        poc_pad_a = 1'b1;
        wait_a(10); clear_pad_a = 1'b1;
        wait_a(140);
        done_a = 1'b1;
    end

    // Instance B stimulus: minimal parameters
    initial begin
        poc_pad_b   = 1'b1;
        clear_pad_b = 1'b0;
        #1 poc_pad_b = 1'b0;
        push_b(0,  M_ALL, V_RST,     "b_reset_state");
        push_b(2,  M_ALL, V_RST,     "b_hold_e2");
        push_b(3,  M_ALL, 6'b100101, "b_clk1_e3");
        push_b(4,  M_ALL, 6'b000101, "b_gap_e4");
        push_b(5,  M_ALL, 6'b011101, "b_clk2_cyc_e5");
        push_b(6,  M_ALL, 6'b000000, "b_poc_fall_e6");
        push_b(7,  M_ALL, 6'b100000, "b_clk1_e7");
        push_b(9,  M_ALL, 6'b011000, "b_clk2_cyc_e9");
        push_b(14, M_CLR, 6'b000000, "b_reject_1cyc_a");
        push_b(18, M_CLR, 6'b000000, "b_reject_1cyc_b");
        push_b(22, M_CLR, 6'b000000, "b_reject_1cyc_c");
        push_b(25, M_CLR, 6'b000000, "b_accept_before_wrap");
        push_b(26, M_CLR, 6'b000011, "b_accept_at_wrap");
        push_b(29, M_CLR, 6'b000011, "b_clear_hold");
        push_b(30, M_CLR, 6'b000000, "b_clear_release");
        repeat (5) @(posedge sysclk);
        #2 poc_pad_b = 1'b1;
        wait_b(10); clear_pad_b = 1'b1;
        wait_b(11); clear_pad_b = 1'b0;
        wait_b(20); clear_pad_b = 1'b1;
        wait_b(22); clear_pad_b = 1'b0;
        wait_b(30);
        done_b = 1'b1;
    end

    // Completion, leftover expectations and summary
    initial begin
        int budget;
        budget = 5000;
        while (!(done_a && done_b) && budget > 0) begin
            @(posedge sysclk);
            budget--;
        end
        if (!(done_a && done_b)) begin
            checks++; failures++;
            $display("FAIL completion: done_a=%b done_b=%b want both 1", done_a, done_b);
        end
        repeat (3) @(negedge sysclk);
        while (qa.size() > 0) begin
            e_f = qa.pop_front();
            checks++; failures++;
            $display("FAIL A %s never checked: due E%0d, at E%0d", e_f.tag, e_f.edge_no, ecnt_a);
        end
        while (qb.size() > 0) begin
            e_f = qb.pop_front();
            checks++; failures++;
            $display("FAIL B %s never checked: due E%0d, at E%0d", e_f.tag, e_f.edge_no, ecnt_b);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard stop if something deadlocks outside the bounded waits
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mcs4_clkrst_gen.md
Name: mcs4_clkrst_gen

Overview:
Clock-phase and reset conditioning stage between the MCS-4 input pads and the mcs4 core. It consumes the padded sysclk, poc_pad and clear_pad nets. From these it produces the non-overlapping two-phase clock enables clk1/clk2, a stretched power-on clear, and a debounced clear that is aligned to phase-period boundaries. The core sees only clean, cycle-aligned reset and phase signals.

Parameters:
DIV, 2, sysclk cycles per quarter phase period; phase period PER = 4*DIV; DIV >= 1
POC_CYCLES, 16, number of full phase periods poc_out is held after reset release; >= 1
DEBOUNCE, 4, consecutive synchronized samples needed to accept a clear_pad change; >= 2

Ports:
sysclk  input  1  system clock; all flops rising-edge
poc_pad  input  1  power-on clear from the pad; asynchronous, active-low reset
clear_pad  input  1  raw external clear request, active-high, asynchronous to sysclk
clk1  output  1  phase-1 enable, registered
clk2  output  1  phase-2 enable, registered
cyc_end  output  1  one-sysclk pulse on the last count of each phase period (ph_cnt == PER-1)
poc_out  output  1  stretched power-on clear to the core, active-high
clear_out  output  1  debounced, period-aligned clear, active-high
core_reset  output  1  poc_out OR clear_out; OR of two registered signals

Behaviour:
- Reset: poc_pad low clears everything immediately.
  - Outputs: clk1=0, clk2=0, cyc_end=0, clear_out=0, core_reset=1, poc_out=1.
  - Internal: ph_cnt=0, poc_cnt=0, deb_cnt=0, clr_state=0, all synchronizer flops=0.
- Reset release:
  - Two-flop synchronizer (rst_s1 -> rst_ok); the D input is tied to 1 and both flops are async-cleared by poc_pad.
  - rst_ok is 1 at the 2nd rising edge after poc_pad rises (edges numbered E1, E2, ...).
- Phase counter:
  - ph_cnt width $clog2(PER).
  - While rst_ok=1: ph_cnt <= (ph_cnt==PER-1) ? 0 : ph_cnt+1.
  - While rst_ok=0: ph_cnt holds 0.
- Phase decode, registered, gated by rst_ok:
  - clk1 <= (ph_cnt < DIV).
  - clk2 <= (ph_cnt >= 2*DIV) && (ph_cnt < 3*DIV).
  - cyc_end is combinational: rst_ok && ph_cnt==PER-1.
  - Result: clk1 and clk2 are each high DIV cycles per PER, are never high together, and have a gap of >= DIV cycles on each side.
  - With DIV=2: clk1 is first high after E3 and E4; clk2 is high after E7 and E8; the period is 8.
- POC stretch:
  - On each edge with cyc_end=1 and poc_out=1: if poc_cnt==POC_CYCLES-1 then poc_out<=0, else poc_cnt++.
  - poc_out falls on the edge where ph_cnt wraps to 0. It never re-asserts without poc_pad going low.
- Clear debounce:
  - clear_pad passes through a 2-flop synchronizer to clr_s2 (async-cleared).
  - If clr_s2 == clr_state: deb_cnt <= 0.
  - Else if deb_cnt == DEBOUNCE-1: clr_state <= clr_s2 and deb_cnt <= 0.
  - Else: deb_cnt++.
  - A level change is accepted after DEBOUNCE consecutive mismatching samples. Any shorter excursion is rejected.
- Clear alignment:
  - clear_out updates only on cyc_end edges: clear_out <= clr_state & ~poc_out, using the pre-edge poc_out.
  - clear_out therefore changes only coincident with a ph_cnt wrap.
  - A clear accepted while poc_out=1 is dropped for that boundary. If clr_state is still 1, clear_out asserts at the first boundary after poc_out falls.
- Assertion and release of clear/reset:
  - clr_state assertion while clear_out=0 appears at the next boundary, i.e. latency <= PER cycles after acceptance.
  - Deassertion is treated the same way, giving a minimum clear_out width of one full period.
- clk1/clk2 keep running during clear_out; only poc_pad stops them.
- Reset mid-operation: poc_pad low at any time forces the reset state asynchronously. Counting restarts from E1 after release, with full POC_CYCLES stretch.

Test Plan:
- Power-up (defaults): hold poc_pad=0 for 5 cycles, release -> all outputs at reset values through E1/E2; clk1=1 after E3,E4; clk2=1 after E7,E8; cyc_end high pre-E10; period 8; clk1&clk2 never both 1.
- POC stretch (defaults): release at E0 -> poc_out=1 through E129, falls at E130 (16th cyc_end edge); core_reset follows.
- Debounce reject/accept after poc_out=0: clear_pad high for 3 cycles -> clr_state, clear_out stay 0; high for 6 cycles -> clr_state rises 5 edges after first high sample edge; clear_out rises at next ph_cnt wrap, stays >= 8 cycles; core_reset=1 while clear_out=1.
- Clear during POC: clear_pad=1 steadily from E10 -> clear_out=0 through E130, rises at E138 (first boundary after poc_out falls).
- Reset mid-operation: poc_pad low for 1 cycle while clk2=1 and clear_out=1 -> immediately clk1=clk2=clear_out=0, poc_out=1; full E1..E130 sequence repeats after release.
- Parameter sweep DIV=1, POC_CYCLES=1, DEBOUNCE=2 -> period 4, clk1 1 cycle, clk2 1 cycle; poc_out falls at E6; 1-cycle clear pulse rejected, 2-cycle accepted.
